instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// MIPS-style instruction encoder: maps a mnemonic class plus operand fields to a
// 32-bit word, queues words in a 2-deep FIFO and tags each delivered word with its byte address.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [31:0] addr,
    output logic        err,
    output logic [15:0] emitted
);

    typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_e;

    fmt_e        fmt;
    logic [5:0]  op, funct;
    logic [4:0]  f_rs, f_rt, f_rd, f_sh;
    logic        legal;
    logic [31:0] enc_word;

    logic [31:0] mem [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count;
    logic        accept, push, pop;

    always_comb begin
        fmt   = FMT_R;
        op    = 6'b000000;
        funct = 6'b000000;
        legal = 1'b1;
        f_rs  = rs;
        f_rt  = rt;
        f_rd  = rd;
        f_sh  = shamt;
        case (mnem)
            5'd0:  begin funct = 6'b100000; f_sh = '0; end
            5'd1:  begin funct = 6'b100001; f_sh = '0; end
            5'd2:  begin funct = 6'b100010; f_sh = '0; end
            5'd3:  begin funct = 6'b100100; f_sh = '0; end
            5'd4:  begin funct = 6'b100101; f_sh = '0; end
            5'd5:  begin funct = 6'b100111; f_sh = '0; end
            5'd6:  begin funct = 6'b101010; f_sh = '0; end
            5'd7:  begin funct = 6'b101011; f_sh = '0; end
            5'd8:  begin funct = 6'b000000; f_rs = '0; end
            5'd9:  begin funct = 6'b000010; f_rs = '0; end
            5'd10: begin funct = 6'b000011; f_rs = '0; end
            5'd11: begin funct = 6'b000100; f_sh = '0; end
            5'd12: begin funct = 6'b000111; f_sh = '0; end
            5'd13: begin funct = 6'b001000; f_rt = '0; f_rd = '0; f_sh = '0; end
            5'd14: begin funct = 6'b001100; f_rs = '0; f_rt = '0; f_rd = '0; f_sh = '0; end
            5'd15: begin fmt = FMT_I; op = 6'b001000; end
            5'd16: begin fmt = FMT_I; op = 6'b001001; end
            5'd17: begin fmt = FMT_I; op = 6'b001100; end
            5'd18: begin fmt = FMT_I; op = 6'b001101; end
            5'd19: begin fmt = FMT_I; op = 6'b001010; end
            5'd20: begin fmt = FMT_I; op = 6'b001111; f_rs = '0; end
            5'd21: begin fmt = FMT_I; op = 6'b100011; end
            5'd22: begin fmt = FMT_I; op = 6'b101011; end
            5'd23: begin fmt = FMT_I; op = 6'b101001; end
            5'd24: begin fmt = FMT_I; op = 6'b000100; end
            5'd25: begin fmt = FMT_I; op = 6'b000101; end
            5'd26: begin fmt = FMT_I; op = 6'b000110; f_rt = '0; end
            5'd27: begin fmt = FMT_J; op = 6'b000010; end
            5'd28: begin fmt = FMT_J; op = 6'b000011; end
            default: legal = 1'b0;
        endcase

        case (fmt)
            FMT_I:   enc_word = {op, f_rs, f_rt, imm};
            FMT_J:   enc_word = {op, target};
            default: enc_word = {op, f_rs, f_rt, f_rd, f_sh, funct};
        endcase
    end

    // Handshake flags depend only on registered occupancy, never on out_ready.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign instr     = out_valid ? mem[rd_ptr] : 32'd0;

    assign accept = in_valid && in_ready;
    assign push   = accept && legal;
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count   <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            addr    <= 32'd0;
            emitted <= 16'd0;
            err     <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= enc_word;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                addr   <= addr + 32'd4;
                if (emitted != 16'hFFFF)
                    emitted <= emitted + 16'd1;
            end
            if (accept && !legal)
                err <= 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
